// File: rtl/gpio_arbiter.sv
// Round-robin owner of the GPIO/LED pad bank: req/gnt handshake, optional
// max-hold preemption, one dead cycle between owners, registered pad drive.
module gpio_arbiter #(
  parameter int                   NUM_REQ    = 4,
  parameter int                   NUM_BITS   = 8,
  parameter int                   MAX_HOLD   = 256,
  parameter logic [NUM_BITS-1:0]  IDLE_VALUE = {NUM_BITS{1'b0}},
  localparam int                  OW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int                  HW         = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*NUM_BITS-1:0]  wdata,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [OW-1:0]                owner,
  output logic                         busy,
  output logic                         preempt,
  output logic [NUM_BITS-1:0]          gpio
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_SWITCH
  } state_e;

  // The counter parks one below MAX_HOLD, so an owner that has already used
  // its quota while alone is revoked as soon as a competitor shows up.
  localparam int             HOLD_SAT_I = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : ((2 ** HW) - 1);
  localparam logic [HW-1:0]  HOLD_SAT   = HW'(HOLD_SAT_I);

  state_e                state_q,   state_d;
  logic [NUM_REQ-1:0]    gnt_q,     gnt_d;
  logic [OW-1:0]         owner_q,   owner_d;
  logic                  busy_q,    busy_d;
  logic                  preempt_q, preempt_d;
  logic [NUM_BITS-1:0]   gpio_q,    gpio_d;
  logic [HW-1:0]         holdCnt_q, holdCnt_d;

  int                    base;
  int                    cand;
  logic [NUM_REQ-1:0]    reqRot;
  logic                  winValid;
  logic [OW-1:0]         winIdx;
  logic [NUM_REQ-1:0]    winOneHot;
  logic [NUM_REQ-1:0]    ownerOneHot;
  logic                  othersReq;
  logic                  ownerReq;
  logic [NUM_BITS-1:0]   ownerData;
  logic [HW-1:0]         holdNext;
  logic                  preemptHit;

  // Rotate req so bit 0 is the requester just after the owner; the owner
  // itself lands in the top bit and is therefore the last candidate.
  always_comb begin
    base = int'(owner_q) + 1;
    if (base >= NUM_REQ) begin
      base = 0;
    end
    reqRot   = NUM_REQ'({req, req} >> base);
    winValid = 1'b0;
    cand     = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!winValid && reqRot[j]) begin
        winValid = 1'b1;
        cand     = base + j;
      end
    end
    if (cand >= NUM_REQ) begin
      cand = cand - NUM_REQ;
    end
    winIdx    = OW'(cand);
    winOneHot = NUM_REQ'(1) << winIdx;
  end

  assign ownerOneHot = NUM_REQ'(1) << owner_q;
  assign othersReq   = |(req & ~ownerOneHot);
  assign ownerReq    = |(req & ownerOneHot);
  assign ownerData   = wdata[owner_q*NUM_BITS +: NUM_BITS];
  assign holdNext    = (holdCnt_q == HOLD_SAT) ? holdCnt_q : holdCnt_q + HW'(1);
  assign preemptHit  = (MAX_HOLD != 0) && (holdCnt_q == HOLD_SAT) && othersReq;

  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    owner_d   = owner_q;
    busy_d    = 1'b0;
    preempt_d = 1'b0;
    gpio_d    = gpio_q;
    holdCnt_d = holdCnt_q;
    unique case (state_q)
      S_IDLE: begin
        gpio_d = IDLE_VALUE;
        if (winValid) begin
          owner_d   = winIdx;
          gnt_d     = winOneHot;
          busy_d    = 1'b1;
          holdCnt_d = '0;
          state_d   = S_GRANT;
        end
      end
      S_GRANT: begin
        if (ownerReq) begin
          gpio_d    = ownerData;
          holdCnt_d = holdNext;
          if (preemptHit) begin
            preempt_d = 1'b1;
            state_d   = S_SWITCH;
          end else begin
            gnt_d  = gnt_q;
            busy_d = 1'b1;
          end
        end else begin
          state_d = S_SWITCH;
        end
      end
      S_SWITCH: begin
        if (winValid) begin
          owner_d   = winIdx;
          gnt_d     = winOneHot;
          busy_d    = 1'b1;
          holdCnt_d = '0;
          state_d   = S_GRANT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Owner resets to the last index so requester 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      owner_q   <= OW'(NUM_REQ - 1);
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      gpio_q    <= IDLE_VALUE;
      holdCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
      gpio_q    <= gpio_d;
      holdCnt_q <= holdCnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;
  assign gpio    = gpio_q;

endmodule

// File: tb/tb_gpio_arbiter.sv
// Bench for gpio_arbiter: directed scenarios plus a randomized run compared
// against a cycle-level ownership model of the arbitration rules.
module tb_gpio_arbiter;

  localparam int          N    = 4;
  localparam int          B    = 8;
  localparam int          MH   = 4;
  localparam logic [7:0]  IDLE = 8'h00;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*B-1:0]    wdata;

  logic [N-1:0]      gnt4,   gnt0;
  logic [1:0]        owner4, owner0;
  logic              busy4,  busy0;
  logic              pre4,   pre0;
  logic [B-1:0]      gpio4,  gpio0;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state: who holds the bank, whether the last cycle was
  // the gap after an owner left, and how many grant cycles the owner used.
  bit          mActive;
  bit          mDead;
  int          mLast;
  int          mHeld;
  logic [N-1:0] eGnt;
  logic [1:0]   eOwner;
  logic         eBusy;
  logic         ePre;
  logic [B-1:0] eGpio;

  always #5 clk = ~clk;

  gpio_arbiter #(.NUM_REQ(N), .NUM_BITS(B), .MAX_HOLD(MH), .IDLE_VALUE(IDLE)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt4), .owner(owner4), .busy(busy4), .preempt(pre4), .gpio(gpio4)
  );

  gpio_arbiter #(.NUM_REQ(N), .NUM_BITS(B), .MAX_HOLD(0), .IDLE_VALUE(IDLE)) dutNoPre (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt0), .owner(owner0), .busy(busy0), .preempt(pre0), .gpio(gpio0)
  );

  function automatic bit reqBit(input logic [N-1:0] r, input int i);
    return ((r >> i) & N'(1)) != '0;
  endfunction

  function automatic int pickWinner(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (reqBit(r, (last + k) % N)) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic void modelAdvance();
    int w;
    logic [N-1:0] others;
    if (rst) begin
      mActive = 1'b0; mDead = 1'b0; mLast = N - 1; mHeld = 0;
      eGnt = '0; eOwner = 2'(N - 1); eBusy = 1'b0; ePre = 1'b0; eGpio = IDLE;
    end else begin
      ePre = 1'b0;
      if (mActive) begin
        if (!reqBit(req, mLast)) begin
          mActive = 1'b0; mDead = 1'b1; eGnt = '0; eBusy = 1'b0;
        end else begin
          eGpio  = wdata[mLast*B +: B];
          mHeld  = mHeld + 1;
          others = req & ~(N'(1) << mLast);
          if (MH != 0 && mHeld >= MH && others != '0) begin
            mActive = 1'b0; mDead = 1'b1; eGnt = '0; eBusy = 1'b0; ePre = 1'b1;
          end
        end
      end else begin
        if (!mDead) eGpio = IDLE;
        mDead = 1'b0;
        w = pickWinner(req, mLast);
        if (w >= 0) begin
          mActive = 1'b1; mLast = w; mHeld = 0;
          eGnt = N'(1) << w; eOwner = 2'(w); eBusy = 1'b1;
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    modelAdvance();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req   = 4'b1111;
    rst   = 1'b1;
    step();
    step();
    nChecks++; if (gnt4 !== 4'b0000) $display("[TB] FAIL reset_gnt: got %b expected %b", gnt4, 4'b0000); else nPass++;
    nChecks++; if (gpio4 !== 8'h00) $display("[TB] FAIL reset_gpio: got %h expected %h", gpio4, 8'h00); else nPass++;
    nChecks++; if (owner4 !== 2'd3) $display("[TB] FAIL reset_owner: got %0d expected %0d", owner4, 3); else nPass++;
    nChecks++; if ({busy4, pre4} !== 2'b00) $display("[TB] FAIL reset_busy_pre: got %b expected %b", {busy4, pre4}, 2'b00); else nPass++;
    rst = 1'b0;
    step();
    nChecks++; if (gnt4 !== 4'b0001) $display("[TB] FAIL reset_first_gnt: got %b expected %b", gnt4, 4'b0001); else nPass++;
    step();
    nChecks++; if (gpio4 !== 8'h11) $display("[TB] FAIL reset_first_gpio: got %h expected %h", gpio4, 8'h11); else nPass++;
  endtask

  task automatic test_single();
    doReset();
    wdata[2*B +: B] = 8'hA5;
    req = 4'b0100;
    step();
    nChecks++; if (gnt4 !== 4'b0100) $display("[TB] FAIL single_gnt: got %b expected %b", gnt4, 4'b0100); else nPass++;
    nChecks++; if (owner4 !== 2'd2) $display("[TB] FAIL single_owner: got %0d expected %0d", owner4, 2); else nPass++;
    step();
    nChecks++; if (gpio4 !== 8'hA5) $display("[TB] FAIL single_gpio_a5: got %h expected %h", gpio4, 8'hA5); else nPass++;
    wdata[2*B +: B] = 8'h3C;
    step();
    nChecks++; if (gpio4 !== 8'h3C) $display("[TB] FAIL single_gpio_3c: got %h expected %h", gpio4, 8'h3C); else nPass++;
    req = 4'b0000;
    step();
    nChecks++; if (gnt4 !== 4'b0000) $display("[TB] FAIL single_release_gnt: got %b expected %b", gnt4, 4'b0000); else nPass++;
    nChecks++; if (gpio4 !== 8'h3C) $display("[TB] FAIL single_release_gpio: got %h expected %h", gpio4, 8'h3C); else nPass++;
    step();
    nChecks++; if (gpio4 !== 8'h3C) $display("[TB] FAIL single_switch_hold: got %h expected %h", gpio4, 8'h3C); else nPass++;
    step();
    nChecks++; if (gpio4 !== 8'h00) $display("[TB] FAIL single_idle_gpio: got %h expected %h", gpio4, 8'h00); else nPass++;
  endtask

  task automatic test_round_robin();
    int order[4] = '{0, 1, 3, 0};
    doReset();
    req = 4'b1011;
    step();
    for (int i = 0; i < 4; i++) begin
      nChecks++; if (gnt0 !== (N'(1) << order[i])) $display("[TB] FAIL rr_grant_%0d: got %b expected %b", i, gnt0, N'(1) << order[i]); else nPass++;
      repeat (4) step();
      nChecks++; if (gnt0 !== (N'(1) << order[i])) $display("[TB] FAIL rr_hold_%0d: got %b expected %b", i, gnt0, N'(1) << order[i]); else nPass++;
      req = req & ~(N'(1) << order[i]);
      step();
      nChecks++; if (gnt0 !== 4'b0000) $display("[TB] FAIL rr_gap_%0d: got %b expected %b", i, gnt0, 4'b0000); else nPass++;
      req = req | (N'(1) << order[i]);
      step();
    end
  endtask

  task automatic test_preempt();
    doReset();
    wdata = $urandom;
    req = 4'b0001;
    step();
    nChecks++; if (gnt4 !== 4'b0001) $display("[TB] FAIL pre_c1: got %b expected %b", gnt4, 4'b0001); else nPass++;
    step();
    nChecks++; if (gnt4 !== 4'b0001) $display("[TB] FAIL pre_c2: got %b expected %b", gnt4, 4'b0001); else nPass++;
    req = 4'b0011;
    step();
    nChecks++; if (gnt4 !== 4'b0001) $display("[TB] FAIL pre_c3: got %b expected %b", gnt4, 4'b0001); else nPass++;
    step();
    nChecks++; if ({gnt4, pre4} !== 5'b00010) $display("[TB] FAIL pre_c4: got %b expected %b", {gnt4, pre4}, 5'b00010); else nPass++;
    step();
    nChecks++; if ({gnt4, pre4} !== 5'b00001) $display("[TB] FAIL pre_revoke: got %b expected %b", {gnt4, pre4}, 5'b00001); else nPass++;
    step();
    nChecks++; if ({gnt4, pre4} !== 5'b00100) $display("[TB] FAIL pre_handover: got %b expected %b", {gnt4, pre4}, 5'b00100); else nPass++;
    nChecks++; if ({gnt0, pre0} !== 5'b00010) $display("[TB] FAIL nopre_kept: got %b expected %b", {gnt0, pre0}, 5'b00010); else nPass++;
    req = 4'b0001;
    step();
    nChecks++; if (gnt4 !== 4'b0000) $display("[TB] FAIL pre_req1_release: got %b expected %b", gnt4, 4'b0000); else nPass++;
    step();
    nChecks++; if (gnt4 !== 4'b0001) $display("[TB] FAIL pre_regrant0: got %b expected %b", gnt4, 4'b0001); else nPass++;
  endtask

  task automatic test_no_preempt_alone();
    int bad4 = 0;
    int bad0 = 0;
    doReset();
    req = 4'b0001;
    step();
    for (int i = 0; i < 100; i++) begin
      step();
      if (gnt4 !== 4'b0001 || pre4 !== 1'b0) bad4++;
      if (gnt0 !== 4'b0001 || pre0 !== 1'b0) bad0++;
    end
    nChecks++; if (bad4 !== 0) $display("[TB] FAIL alone_revoked: got %0d bad cycles expected %0d", bad4, 0); else nPass++;
    nChecks++; if (bad0 !== 0) $display("[TB] FAIL alone_revoked_nohold: got %0d bad cycles expected %0d", bad0, 0); else nPass++;
  endtask

  task automatic test_reset_mid_grant();
    doReset();
    wdata[2*B +: B] = 8'hFF;
    req = 4'b0100;
    step();
    step();
    nChecks++; if ({owner4, gpio4} !== {2'd2, 8'hFF}) $display("[TB] FAIL mid_setup: got %h expected %h", {owner4, gpio4}, {2'd2, 8'hFF}); else nPass++;
    rst = 1'b1;
    req = 4'b1111;
    step();
    nChecks++; if ({gnt4, gpio4, owner4} !== {4'b0000, 8'h00, 2'd3}) $display("[TB] FAIL mid_reset: got %h expected %h", {gnt4, gpio4, owner4}, {4'b0000, 8'h00, 2'd3}); else nPass++;
    rst = 1'b0;
    step();
    nChecks++; if (gnt4 !== 4'b0001) $display("[TB] FAIL mid_rearb: got %b expected %b", gnt4, 4'b0001); else nPass++;
  endtask

  task automatic test_random();
    doReset();
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(5, 0) == 0) req = req ^ (N'(1) << b);
      end
      wdata = $urandom;
      rst   = ($urandom_range(149, 0) == 0);
      step();
      nChecks++;
      if ({gnt4, owner4, busy4, pre4, gpio4} !== {eGnt, eOwner, eBusy, ePre, eGpio})
        $display("[TB] FAIL random_cycle_%0d: got gnt=%b owner=%0d busy=%b pre=%b gpio=%h expected gnt=%b owner=%0d busy=%b pre=%b gpio=%h",
                 c, gnt4, owner4, busy4, pre4, gpio4, eGnt, eOwner, eBusy, ePre, eGpio);
      else nPass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    wdata = '0;
    $display("[TB] starting gpio_arbiter bench");
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_no_preempt_alone();
    test_reset_mid_grant();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
